// File: rtl/josh_pkg.sv
// josh_pkg: shared types and default geometry for the JOSH Jump display path.
// Holds the renderer state encoding, palette constants and a safe clog2.
package josh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIELD,
    DRAIN,
    SPRITE,
    DONE
  } state_t;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_RED   = 3'b100;

  localparam int DEF_PF_W  = 120;
  localparam int DEF_PF_H  = 100;
  localparam int DEF_X0    = 20;
  localparam int DEF_Y0    = 10;
  localparam int DEF_SPR_W = 4;
  localparam int DEF_SPR_H = 6;

  // A 1-wide or 1-high rectangle still needs a 1-bit counter.
  function automatic int clog2s(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_renderer_if.sv
// frame_renderer_if: frame control, bitmap read port and vga pixel port.
// master is the renderer, slave is the game datapath / memory / adapter.
interface frame_renderer_if
  import josh_pkg::*;
#(
  parameter int PF_W = DEF_PF_W,
  parameter int PF_H = DEF_PF_H,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3
);

  localparam int CLW = clog2s(PF_W);
  localparam int RWW = clog2s(PF_H);

  logic          start;
  logic [XW-1:0] sprite_x;
  logic [YW-1:0] sprite_y;
  logic [CW-1:0] sprite_colour;
  logic          busy;
  logic          done;

  logic           rd_en;
  logic [CLW-1:0] rd_col;
  logic [RWW-1:0] rd_row;
  logic           rd_data;

  logic          plot;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;

  modport master (
    input  start, sprite_x, sprite_y, sprite_colour, rd_data,
    output busy, done, rd_en, rd_col, rd_row,
    output plot, x, y, colour
  );

  modport slave (
    output start, sprite_x, sprite_y, sprite_colour, rd_data,
    input  busy, done, rd_en, rd_col, rd_row,
    input  plot, x, y, colour
  );

endinterface

// File: rtl/rect_scanner.sv
// rect_scanner: column-major (W,H) counter pair; row is the fast index.
// clear wins over step; last flags the final (W-1,H-1) position.
module rect_scanner
  import josh_pkg::*;
#(
  parameter int W   = DEF_SPR_W,
  parameter int H   = DEF_SPR_H,
  parameter int CLW = clog2s(W),
  parameter int RWW = clog2s(H)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           step,
  output logic [CLW-1:0] col,
  output logic [RWW-1:0] row,
  output logic           last
);

  logic row_end;

  always_comb begin
    row_end = (row == RWW'(H - 1));
    last    = row_end && (col == CLW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (row_end) begin
        row <= '0;
        col <= col + 1'b1;
      end else begin
        row <= row + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_renderer.sv
// frame_renderer: sweeps the playfield bitmap, then draws the sprite.
// Define SPRITE_CLIP_EN to suppress sprite pixels outside the playfield.
module frame_renderer
  import josh_pkg::*;
#(
  parameter int PF_W  = DEF_PF_W,
  parameter int PF_H  = DEF_PF_H,
  parameter int X0    = DEF_X0,
  parameter int Y0    = DEF_Y0,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 3,
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H,
  parameter logic [CW-1:0] FG_COLOUR = CW'(COL_WHITE),
  parameter logic [CW-1:0] BG_COLOUR = CW'(COL_BLACK)
) (
  input  logic             clk,
  input  logic             resetn,
  frame_renderer_if.master bus
);

  localparam int CLW = clog2s(PF_W);
  localparam int RWW = clog2s(PF_H);
  localparam int SXW = clog2s(SPR_W);
  localparam int SYW = clog2s(SPR_H);

  state_t state;

  logic [XW-1:0] spx;
  logic [YW-1:0] spy;
  logic [CW-1:0] spc;

  logic          busy_r;
  logic          done_r;
  logic          rd_en_r;
  logic          plot_r;
  logic          fld_px;
  logic          spr_end;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [CW-1:0] col_r;

  logic [CLW-1:0] f_col;
  logic [RWW-1:0] f_row;
  logic           f_last;
  logic [SXW-1:0] s_col;
  logic [SYW-1:0] s_row;
  logic           s_last;

  logic          accept;
  logic          f_step;
  logic          s_emit;
  logic          s_step;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          p_ok;
  logic [CW-1:0] pix_col;

  rect_scanner #(
    .W(PF_W),
    .H(PF_H)
  ) u_field (
    .clk   (clk),
    .resetn(resetn),
    .clear (accept),
    .step  (f_step),
    .col   (f_col),
    .row   (f_row),
    .last  (f_last)
  );

  // Runs one pixel ahead of the plotted sprite pixel.
  rect_scanner #(
    .W(SPR_W),
    .H(SPR_H)
  ) u_sprite (
    .clk   (clk),
    .resetn(resetn),
    .clear (accept),
    .step  (s_step),
    .col   (s_col),
    .row   (s_row),
    .last  (s_last)
  );

  always_comb begin
    accept = (state == IDLE) && bus.start;
    f_step = (state == FIELD) && !f_last;
    s_emit = (state == DRAIN) ||
             ((state == SPRITE) && !spr_end);
    s_step = s_emit && !s_last;
    px     = spx + XW'(s_col);
    py     = spy + YW'(s_row);
`ifdef SPRITE_CLIP_EN
    p_ok   = (int'(px) >= X0) &&
             (int'(px) <= X0 + PF_W - 1) &&
             (int'(py) >= Y0) &&
             (int'(py) <= Y0 + PF_H - 1);
`else
    p_ok   = 1'b1;
`endif
    // Bitmap data lands one cycle after the read, alongside x/y.
    pix_col = fld_px ?
              (bus.rd_data ? FG_COLOUR : BG_COLOUR) :
              col_r;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      plot_r  <= 1'b0;
      fld_px  <= 1'b0;
      spr_end <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
      col_r   <= '0;
      spx     <= '0;
      spy     <= '0;
      spc     <= '0;
    end else begin
      done_r <= 1'b0;
      plot_r <= 1'b0;
      fld_px <= 1'b0;
      if (fld_px) col_r <= pix_col;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= FIELD;
            busy_r  <= 1'b1;
            rd_en_r <= 1'b1;
            spr_end <= 1'b0;
            spx     <= bus.sprite_x;
            spy     <= bus.sprite_y;
            spc     <= bus.sprite_colour;
          end
        end
        FIELD: begin
          plot_r <= 1'b1;
          fld_px <= 1'b1;
          x_r    <= XW'(X0) + XW'(f_col);
          y_r    <= YW'(Y0) + YW'(f_row);
          if (f_last) begin
            rd_en_r <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN, SPRITE: begin
          if ((state == SPRITE) && spr_end) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            state   <= SPRITE;
            spr_end <= s_last;
            plot_r  <= p_ok;
            if (p_ok) begin
              x_r   <= px;
              y_r   <= py;
              col_r <= spc;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.rd_en  = rd_en_r;
  assign bus.rd_col = f_col;
  assign bus.rd_row = f_row;
  assign bus.plot   = plot_r;
  assign bus.x      = x_r;
  assign bus.y      = y_r;
  assign bus.colour = pix_col;

endmodule

// File: tb/tb_frame_renderer.sv
// tb_frame_renderer: directed checks on a 2x2 field and the default field.
// Expected pixels come from a bitmap function and a sprite pixel list.
module tb_frame_renderer;
  import josh_pkg::*;

`ifdef SPRITE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   ncmp;
  int   nfail;

  int r_done;
  int r_plot;
  int r_spr;
  int r_first;
  int r_busy_bad;
  int r_fld_bad;
  int r_spr_bad;

  frame_renderer_if #(
    .PF_W(2), .PF_H(2), .XW(8), .YW(7), .CW(3)
  ) bs ();

  frame_renderer_if #(
    .PF_W(120), .PF_H(100), .XW(8), .YW(7), .CW(3)
  ) bd ();

  frame_renderer #(
    .PF_W(2), .PF_H(2), .X0(20), .Y0(10),
    .XW(8), .YW(7), .CW(3),
    .SPR_W(1), .SPR_H(1)
  ) dut_s (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bs)
  );

  frame_renderer dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit sbm(input int c, input int r);
    return c == r;
  endfunction

  function automatic bit bmd(input int c, input int r);
    return ((c + 2 * r) % 3) == 0;
  endfunction

  always @(posedge clk) begin
    if (bs.rd_en)
      bs.rd_data <= sbm(int'(bs.rd_col), int'(bs.rd_row));
    if (bd.rd_en)
      bd.rd_data <= bmd(int'(bd.rd_col), int'(bd.rd_row));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic big_frame(input logic [7:0] sx,
                           input logic [6:0] sy,
                           input logic [2:0] sc,
                           input int pulse_at,
                           input int move_at);
    logic [7:0] ex[$];
    logic [6:0] ey[$];
    logic [7:0] tx;
    logic [6:0] ty;
    logic [2:0] ec;
    int k;
    int c;
    int r;
    int j;
    int cyc;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 6; b++) begin
        tx = sx + 8'(a);
        ty = sy + 7'(b);
        if (!CLIP || (tx >= 20 && tx <= 139 &&
                      ty >= 10 && ty <= 109)) begin
          ex.push_back(tx);
          ey.push_back(ty);
        end
      end
    end
    r_done = -1;
    r_first = -1;
    r_busy_bad = 0;
    r_fld_bad = 0;
    r_spr_bad = 0;
    k = 0;
    bd.sprite_x = sx;
    bd.sprite_y = sy;
    bd.sprite_colour = sc;
    bd.start = 1'b1;
    tick();
    bd.start = 1'b0;
    cyc = 1;
    while (cyc <= 13000) begin
      if (bd.done) begin
        r_done = cyc;
        break;
      end
      if (!bd.busy) r_busy_bad++;
      if (bd.plot) begin
        if (r_first < 0) r_first = cyc;
        if (k < 12000) begin
          c = k / 100;
          r = k % 100;
          ec = bmd(c, r) ? 3'd7 : 3'd0;
          if (bd.x !== 8'(20 + c) || bd.y !== 7'(10 + r) ||
              bd.colour !== ec)
            r_fld_bad++;
        end else begin
          j = k - 12000;
          if (j >= ex.size()) r_spr_bad++;
          else if (bd.x !== ex[j] || bd.y !== ey[j] ||
                   bd.colour !== sc)
            r_spr_bad++;
        end
        k++;
      end
      bd.start = (cyc == pulse_at);
      if (cyc == move_at) begin
        bd.sprite_x = ~sx;
        bd.sprite_y = ~sy;
        bd.sprite_colour = ~sc;
      end
      tick();
      cyc++;
    end
    bd.start = 1'b0;
    r_plot = k;
    r_spr = (k > 12000) ? k - 12000 : 0;
    tick();
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    resetn = 1'b0;
    bs.start = 1'b0;
    bs.sprite_x = '0;
    bs.sprite_y = '0;
    bs.sprite_colour = '0;
    bd.start = 1'b0;
    bd.sprite_x = '0;
    bd.sprite_y = '0;
    bd.sprite_colour = '0;
    repeat (3) tick();
    resetn = 1'b1;

    chk("rst_ctl", {bd.busy, bd.done, bd.plot, bd.rd_en}, 0);
    chk("rst_xyc", {bd.x, bd.y, bd.colour}, 0);
    chk("rst_rd", {bd.rd_col, bd.rd_row}, 0);
    chk("rst_s_ctl", {bs.busy, bs.done, bs.plot, bs.rd_en}, 0);
    tick();

    // Small field; start held high through the whole frame.
    bs.sprite_x = 8'd5;
    bs.sprite_y = 7'd5;
    bs.sprite_colour = COL_RED;
    bs.start = 1'b1;
    tick();
    chk("s_c1_ctl", {bs.busy, bs.rd_en, bs.plot}, 3'b110);
    chk("s_c1_addr", {bs.rd_col, bs.rd_row}, 0);
    tick();
    chk("s_c2_px", {bs.plot, bs.x, bs.y, bs.colour},
        {1'b1, 8'd20, 7'd10, 3'd7});
    chk("s_c2_addr", {bs.rd_col, bs.rd_row}, 2'b01);
    tick();
    chk("s_c3_px", {bs.plot, bs.x, bs.y, bs.colour},
        {1'b1, 8'd20, 7'd11, 3'd0});
    tick();
    chk("s_c4_px", {bs.plot, bs.x, bs.y, bs.colour},
        {1'b1, 8'd21, 7'd10, 3'd0});
    tick();
    chk("s_c5_px", {bs.plot, bs.x, bs.y, bs.colour},
        {1'b1, 8'd21, 7'd11, 3'd7});
    chk("s_c5_rden", bs.rd_en, 0);
    tick();
    chk("s_c6_spr", {bs.plot, bs.x, bs.y, bs.colour},
        {1'b1, 8'd5, 7'd5, 3'd4});
    chk("s_c6_ctl", {bs.busy, bs.done}, 2'b10);
    tick();
    chk("s_c7_done", {bs.busy, bs.done, bs.plot}, 3'b010);
    chk("s_c7_hold", {bs.x, bs.y, bs.colour},
        {8'd5, 7'd5, 3'd4});
    tick();
    chk("s_c8_idle", {bs.busy, bs.done, bs.rd_en}, 0);
    tick();
    chk("s_c9_restart", {bs.busy, bs.rd_en}, 2'b11);
    bs.start = 1'b0;
    repeat (10) tick();
    chk("s_end_idle", {bs.busy, bs.done, bs.plot}, 0);

    // Mid-frame start pulse, sprite inputs moved after acceptance.
    big_frame(8'd30, 7'd40, COL_RED, 50, 1);
    chk("a_done_cyc", r_done, 12026);
    chk("a_plot_cnt", r_plot, 12024);
    chk("a_first", r_first, 2);
    chk("a_busy", r_busy_bad, 0);
    chk("a_field", r_fld_bad, 0);
    chk("a_sprite", r_spr_bad, 0);
    chk("a_idle", {bd.busy, bd.done, bd.plot}, 0);

    // Sprite straddling the bottom-right corner of the field.
    big_frame(8'd138, 7'd108, 3'b010, -1, -1);
    chk("b_done_cyc", r_done, 12026);
    chk("b_spr_cnt", r_spr, CLIP ? 4 : 24);
    chk("b_field", r_fld_bad, 0);
    chk("b_sprite", r_spr_bad, 0);

    // Reset in the middle of a frame.
    bd.sprite_x = 8'd60;
    bd.sprite_y = 7'd60;
    bd.sprite_colour = 3'b001;
    bd.start = 1'b1;
    tick();
    bd.start = 1'b0;
    repeat (29) tick();
    chk("r_c30_plot", {bd.busy, bd.plot}, 2'b11);
    resetn = 1'b0;
    tick();
    chk("r_c31_ctl", {bd.busy, bd.done, bd.plot, bd.rd_en}, 0);
    chk("r_c31_xyc", {bd.x, bd.y, bd.colour}, 0);
    resetn = 1'b1;
    tick();
    big_frame(8'd50, 7'd20, 3'b011, -1, -1);
    chk("c_done_cyc", r_done, 12026);
    chk("c_plot_cnt", r_plot, 12024);
    chk("c_first", r_first, 2);
    chk("c_field", r_fld_bad, 0);
    chk("c_sprite", r_spr_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/frame_renderer.md
Name: frame_renderer

Overview:
- Parametrised raster draw engine for the JOSH Jump display path. It replaces the ad-hoc wall/dude counters that fed `vga_adapter`.
- On a `start` pulse it sweeps the playfield bitmap held in external column storage, one pixel per clock. It then draws the player sprite rectangle.
- It emits `plot`/`x`/`y`/`colour` writes that connect directly to the `vga_adapter` pixel port.
- It sits between the game datapath (bitmap owner, sprite position) and `vga_adapter`.

Parameters:
- PF_W, 120, playfield width in columns.
- PF_H, 100, playfield height in rows.
- X0, 20, screen x of playfield column 0.
- Y0, 10, screen y of playfield row 0.
- XW, 8, screen x width; must hold X0+PF_W-1.
- YW, 7, screen y width; must hold Y0+PF_H-1.
- CW, 3, colour width.
- SPR_W, 4, sprite width in pixels.
- SPR_H, 6, sprite height in pixels.
- FG_COLOUR, 3'b111, colour for bitmap 1.
- BG_COLOUR, 3'b000, colour for bitmap 0.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- start  in  1  begin frame; sampled only in IDLE
- sprite_x  in  XW  sprite top-left screen x; latched at accepted start
- sprite_y  in  YW  sprite top-left screen y; latched at accepted start
- sprite_colour  in  CW  sprite colour; latched at accepted start
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  single-cycle pulse at frame completion
- rd_en  out  1  bitmap read strobe
- rd_col  out  $clog2(PF_W)  bitmap column address
- rd_row  out  $clog2(PF_H)  bitmap row address
- rd_data  in  1  bitmap bit; valid exactly one cycle after rd_en
- plot  out  1  pixel write enable
- x  out  XW  pixel x
- y  out  YW  pixel y
- colour  out  CW  pixel colour

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. On reset: state IDLE; busy, done, plot, rd_en = 0; x, y, colour, rd_col, rd_row = 0; latched sprite registers = 0.
- Reset mid-frame: abort immediately; the next cycle shows reset values. No partial writes occur after reset.
- States and transitions:
  - IDLE: start=1 -> FIELD; latch sprite inputs; col=row=0.
  - FIELD: each cycle rd_en=1 with (rd_col, rd_row). Scan is column-major: row increments first, wraps to 0 at PF_H-1 and increments col. After issuing (PF_W-1, PF_H-1) -> DRAIN.
  - DRAIN: one cycle; no read; retires the last pipelined pixel -> SPRITE.
  - SPRITE: sx=0..SPR_W-1 outer, sy=0..SPR_H-1 inner. plot=1 with x=sprite_x+sx, y=sprite_y+sy, colour=latched sprite_colour. After the last pixel -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Field pixel pipeline:
  - A read issued at cycle t for (c,r) produces at t+1: plot=1, x=X0+c, y=Y0+r, colour = rd_data ? FG_COLOUR : BG_COLOUR.
  - plot is continuous from cycle 2 to cycle 1+PF_W*PF_H, where cycle 1 is the first FIELD cycle.
- Sprite writes follow field writes with no gap; the first sprite write is in the cycle after DRAIN.
- Frame length: start accepted at cycle 0 -> done at cycle PF_W*PF_H + SPR_W*SPR_H + 2.
- Overlap rule: the sprite is always drawn after the field, so the sprite wins on overlap.
- start while busy: ignored, no queueing. start in the DONE cycle: ignored. start held high: a new frame begins on the cycle after done.
- Arithmetic: screen coordinate sums are truncated modulo 2^XW / 2^YW. x, y, colour hold their last value when plot=0.

Optional Feature:
- Macro: SPRITE_CLIP_EN.
- Defined: sprite pixels with x outside [X0, X0+PF_W-1] or y outside [Y0, Y0+PF_H-1] are suppressed. plot=0 for that cycle, but the cycle is still consumed, so frame length is unchanged.
- Undefined: every sprite pixel is plotted, with coordinates wrapping modulo the port widths.

Decomposition:
- Package josh_pkg holds:
  - state enum (IDLE, FIELD, DRAIN, SPRITE, DONE);
  - colour constants (COL_BLACK, COL_WHITE, COL_RED);
  - default geometry constants (PF_W/PF_H/X0/Y0/SPR_W/SPR_H).
- One sub-module: rect_scanner, a parametrised column-major (W,H) counter pair with clear, step and last outputs. It is instantiated twice: field and sprite.

Test Plan:
- PF_W=2, PF_H=2, SPR_W=1, SPR_H=1, bitmap {c0:1,0; c1:0,1}, start with sprite (5,5,3'b100) -> plot cycles 2..5:
  - (20,10,7), (20,11,0), (21,10,0), (21,11,7);
  - cycle 6: (5,5,4);
  - done pulses at cycle 7.
- Default params, start -> busy high for the whole frame; done exactly at cycle 12026; exactly 12024 plot cycles.
- start pulsed at cycle 50 mid-frame -> ignored; frame length and output unchanged.
- resetn low at cycle 30 -> next cycle plot=0, busy=0, rd_en=0; a following start produces a full fresh frame from (20,10).
- sprite_x changed after start -> sprite drawn at the latched position.
- SPRITE_CLIP_EN defined, sprite at (138,108) -> only in-range pixels plotted; done still at cycle 12026. Undefined: all 24 sprite pixels plotted.
